// File: rtl/hps_job_event_bridge.sv
`default_nettype none
// ============================================================================
// Module   : hps_job_event_bridge
// Purpose  : Bridges the HPS MPU event conduits to the image-filter
//            accelerator. A rising edge on the MPU event output starts a
//            job. Job state, flags and row count are published on the HPS
//            loan GPI inputs. Completion pulses the MPU event input, which
//            wakes a core waiting in WFE.
// Ports    : clk_clk        - system clock
//            reset_reset    - synchronous active-high reset
//            mpu_evento     - SEV from the MPU (asynchronous to clk_clk)
//            mpu_eventi     - wake pulse to the MPU, EVENTI_PULSE cycles wide
//            gpi[13:0]      - {rows[9:0], timeout, error, state[1:0]}
//            acc_start      - one-cycle job start to the accelerator
//            acc_row_strobe - one pulse per completed row
//            acc_done       - one-cycle job-complete pulse
//            acc_error      - job error, valid only while acc_done is high
// Revision : 1.0 - initial release
// ============================================================================
module hps_job_event_bridge #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10000000,
    parameter int unsigned EVENTI_PULSE   = 4
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        mpu_evento,
    output logic        mpu_eventi,
    output logic [13:0] gpi,
    output logic        acc_start,
    input  logic        acc_row_strobe,
    input  logic        acc_done,
    input  logic        acc_error
);

    // State codes are chosen to match the gpi[1:0] encoding, so the state
    // register drives the GPI field directly.
    localparam logic [1:0] c_ST_IDLE  = 2'b00;
    localparam logic [1:0] c_ST_BUSY  = 2'b01;
    localparam logic [1:0] c_ST_DONE  = 2'b10;
    localparam logic [1:0] c_ST_START = 2'b11;

    localparam logic [3:0] c_PULSE_LEN = 4'(EVENTI_PULSE);
    localparam logic [9:0] c_ROW_MAX   = 10'd1023;

    logic        r_ev_meta;
    logic        r_ev_sync;
    logic        r_ev_prev;
    logic        r_ev_rise;
    logic [1:0]  r_state;
    logic [9:0]  r_rows;
    logic        r_err;
    logic        r_tmo;
    logic [23:0] r_tcount;
    logic        r_acc_start;
    logic [3:0]  r_pulse_cnt;
    logic        r_eventi;

    logic [23:0] w_tcount_next;
    logic        w_timeout_hit;
    logic [9:0]  w_rows_next;

    assign w_tcount_next = r_tcount + 24'd1;
    // Evaluated on the incremented value so that the job leaves BUSY after
    // exactly TIMEOUT_CYCLES busy cycles.
    assign w_timeout_hit = (TIMEOUT_CYCLES != 24'd0) && (w_tcount_next == TIMEOUT_CYCLES);
    assign w_rows_next   = (acc_row_strobe && (r_rows != c_ROW_MAX)) ? r_rows + 10'd1 : r_rows;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_ev_meta   <= 1'b0;
            r_ev_sync   <= 1'b0;
            r_ev_prev   <= 1'b0;
            r_ev_rise   <= 1'b0;
            r_state     <= c_ST_IDLE;
            r_rows      <= 10'd0;
            r_err       <= 1'b0;
            r_tmo       <= 1'b0;
            r_tcount    <= 24'd0;
            r_acc_start <= 1'b0;
            r_pulse_cnt <= 4'd0;
            r_eventi    <= 1'b0;
        end else begin
            // Two-flop synchronizer followed by a registered edge detect.
            r_ev_meta <= mpu_evento;
            r_ev_sync <= r_ev_meta;
            r_ev_prev <= r_ev_sync;
            r_ev_rise <= r_ev_sync & ~r_ev_prev;

            r_acc_start <= 1'b0;

            // The wake pulse runs to completion independent of the FSM, so a
            // new job started mid-pulse does not truncate it.
            if (r_pulse_cnt != 4'd0) begin
                r_eventi    <= 1'b1;
                r_pulse_cnt <= r_pulse_cnt - 4'd1;
            end else begin
                r_eventi <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    // Status is cleared on the same edge that enters START so
                    // the GPI reads clean while acc_start is high.
                    if (r_ev_rise) begin
                        r_state     <= c_ST_START;
                        r_acc_start <= 1'b1;
                        r_rows      <= 10'd0;
                        r_err       <= 1'b0;
                        r_tmo       <= 1'b0;
                        r_tcount    <= 24'd0;
                    end
                end
                c_ST_START: begin
                    r_state <= c_ST_BUSY;
                end
                c_ST_BUSY: begin
                    r_tcount <= w_tcount_next;
                    r_rows   <= w_rows_next;
                    // Done takes priority over a coincident timeout.
                    if (acc_done) begin
                        r_state     <= c_ST_DONE;
                        r_err       <= acc_error;
                        r_pulse_cnt <= c_PULSE_LEN;
                    end else if (w_timeout_hit) begin
                        r_state     <= c_ST_DONE;
                        r_tmo       <= 1'b1;
                        r_pulse_cnt <= c_PULSE_LEN;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign gpi        = {r_rows, r_tmo, r_err, r_state};
    assign acc_start  = r_acc_start;
    assign mpu_eventi = r_eventi;

endmodule
`default_nettype wire

// File: tb/tb_hps_job_event_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_hps_job_event_bridge
// Purpose  : Self-checking bench for hps_job_event_bridge. Instance A uses the
//            default timeout; instance B uses a 100-cycle timeout. Expected
//            job-end GPI words are queued when a job is finished by stimulus
//            and compared when the wake pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hps_job_event_bridge;

    logic        clk;
    logic        rst;

    logic        evento_a, eventi_a, start_a, strobe_a, done_a, error_a;
    logic [13:0] gpi_a;
    logic        evento_b, eventi_b, start_b, strobe_b, done_b, error_b;
    logic [13:0] gpi_b;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] exp_q[$];

    hps_job_event_bridge u_dut_a (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .mpu_evento     (evento_a),
        .mpu_eventi     (eventi_a),
        .gpi            (gpi_a),
        .acc_start      (start_a),
        .acc_row_strobe (strobe_a),
        .acc_done       (done_a),
        .acc_error      (error_a)
    );

    hps_job_event_bridge #(
        .TIMEOUT_CYCLES (24'd100),
        .EVENTI_PULSE   (4)
    ) u_dut_b (
        .clk_clk        (clk),
        .reset_reset    (rst),
        .mpu_evento     (evento_b),
        .mpu_eventi     (eventi_b),
        .gpi            (gpi_b),
        .acc_start      (start_b),
        .acc_row_strobe (strobe_b),
        .acc_done       (done_b),
        .acc_error      (error_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] gpi_of(input bit sel);
        return sel ? gpi_b : gpi_a;
    endfunction

    function automatic logic eventi_of(input bit sel);
        return sel ? eventi_b : eventi_a;
    endfunction

    function automatic logic start_of(input bit sel);
        return sel ? start_b : start_a;
    endfunction

    task automatic set_evento(input bit sel, input logic v);
        if (sel) evento_b = v;
        else     evento_a = v;
    endtask

    // One-cycle SEV pulse, then wait for acc_start. Returns in the START cycle.
    task automatic start_job(input bit sel);
        int lat;
        set_evento(sel, 1'b1);
        tick();
        set_evento(sel, 1'b0);
        lat = 1;
        while (start_of(sel) !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        chk("start_seen", start_of(sel), 1);
        chk("start_latency", lat, 4);
        chk("start_gpi", gpi_of(sel), 14'h0003);
    endtask

    // Wait for the wake pulse, compare the job result, and measure the pulse.
    task automatic wait_eventi(input bit sel, input int exp_lat);
        int lat;
        int width;
        int extra;
        logic [13:0] e;
        lat = 0;
        while (eventi_of(sel) !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        chk("eventi_seen", eventi_of(sel), 1);
        chk("eventi_latency", lat, exp_lat);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("job_gpi", gpi_of(sel), e);
        end
        width = 0;
        while (eventi_of(sel) === 1'b1 && width < 20) begin
            tick();
            width++;
        end
        chk("eventi_width", width, 4);
        extra = 0;
        repeat (10) begin
            tick();
            if (eventi_of(sel) !== 1'b0) extra++;
        end
        chk("eventi_once", extra, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        evento_a = 0; strobe_a = 0; done_a = 0; error_a = 0;
        evento_b = 0; strobe_b = 0; done_b = 0; error_b = 0;
        repeat (3) tick();
        chk("rst_gpi_a", gpi_a, 14'h0000);
        chk("rst_start_a", start_a, 0);
        chk("rst_eventi_a", eventi_a, 0);
        chk("rst_gpi_b", gpi_b, 14'h0000);
        rst = 1'b0;
        tick();

        // Start latency and state sequence.
        start_job(0);
        tick();
        chk("start_one_cycle", start_a, 0);
        chk("state_busy", gpi_a[1:0], 2'b01);

        // Five rows, clean completion.
        repeat (5) begin strobe_a = 1; tick(); end
        strobe_a = 0;
        done_a = 1;
        exp_q.push_back(14'h0052);
        tick();
        done_a = 0;
        chk("done_state", gpi_a[1:0], 2'b10);
        wait_eventi(0, 1);

        // Timeout after 100 busy cycles.
        start_job(1);
        repeat (100) tick();
        chk("tmo_still_busy", gpi_b[1:0], 2'b01);
        exp_q.push_back(14'h000A);
        tick();
        chk("tmo_done", gpi_b[1:0], 2'b10);
        chk("tmo_flag", gpi_b[3], 1);
        wait_eventi(1, 1);

        // Done in the 100th busy cycle beats the timeout.
        start_job(1);
        repeat (100) tick();
        chk("tmo2_still_busy", gpi_b[1:0], 2'b01);
        done_b = 1;
        exp_q.push_back(14'h0002);
        tick();
        done_b = 0;
        chk("tmo2_flag_clear", gpi_b[3], 0);
        wait_eventi(1, 1);

        // Row count saturation with error; new job from DONE clears status.
        start_job(0);
        tick();
        strobe_a = 1;
        repeat (1030) tick();
        strobe_a = 0;
        chk("rows_sat", gpi_a[13:4], 10'd1023);
        done_a = 1; error_a = 1;
        exp_q.push_back(14'h3FF6);
        tick();
        done_a = 0; error_a = 0;
        wait_eventi(0, 1);

        // SEV during BUSY is ignored; strobe coincident with done is counted.
        start_job(0);
        tick();
        evento_a = 1;
        tick();
        evento_a = 0;
        n = 0;
        repeat (10) begin tick(); if (start_a === 1'b1) n++; end
        chk("busy_ev_ignored", n, 0);
        chk("busy_ev_state", gpi_a[1:0], 2'b01);
        strobe_a = 1;
        tick();
        done_a = 1;
        exp_q.push_back(14'h0022);
        tick();
        strobe_a = 0; done_a = 0;
        wait_eventi(0, 1);

        // Held-high SEV yields exactly one job start.
        evento_a = 1;
        n = 0;
        repeat (50) begin tick(); if (start_a === 1'b1) n++; end
        evento_a = 0;
        repeat (10) begin tick(); if (start_a === 1'b1) n++; end
        chk("held_single_start", n, 1);
        done_a = 1;
        exp_q.push_back(14'h0002);
        tick();
        done_a = 0;
        wait_eventi(0, 1);

        // Reset mid-job aborts silently; later done is ignored in IDLE.
        start_job(0);
        tick();
        repeat (3) begin strobe_a = 1; tick(); end
        strobe_a = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("midrst_gpi", gpi_a, 14'h0000);
        chk("midrst_start", start_a, 0);
        chk("midrst_eventi", eventi_a, 0);
        done_a = 1;
        tick();
        done_a = 0;
        n = 0;
        repeat (10) begin tick(); if (eventi_a !== 1'b0) n++; end
        chk("idle_done_gpi", gpi_a, 14'h0000);
        chk("idle_done_no_eventi", n, 0);

        chk("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hps_job_event_bridge.md
Name: hps_job_event_bridge

Overview:
- FPGA-side control/status stage sitting directly on the HPS conduits of the interconexion system.
- Consumes the MPU event output (SEV from the filter software) as a "start filter job" command and issues a one-cycle start to the image-filter accelerator.
- Tracks accelerator progress and completion, and reports state, flags and row count on the 14 HPS loan GPI inputs (HLGPI0..13).
- On job end, pulses the MPU event input to wake a core parked in WFE.

Parameters:
- TIMEOUT_CYCLES, 24'd10000000: BUSY cycles allowed before the job is forced to DONE with the timeout flag; 0 disables the timeout.
- EVENTI_PULSE, 4: width, in clk_clk cycles, of the mpu_eventi pulse (range 1..15).

Ports:
- clk_clk  in  1  single system clock.
- reset_reset  in  1  synchronous, active-high reset.
- mpu_evento  in  1  from hps_h2f_mpu_events_evento; asynchronous to clk_clk; guaranteed high for at least 1 clk_clk period.
- mpu_eventi  out  1  to hps_h2f_mpu_events_eventi.
- gpi  out  14  to HLGPI13..HLGPI0 (bit n drives HLGPIn).
- acc_start  out  1  one-cycle job start pulse to the accelerator.
- acc_row_strobe  in  1  one-cycle pulse per completed image row.
- acc_done  in  1  one-cycle job-complete pulse.
- acc_error  in  1  accelerator error; sampled only in the cycle acc_done is high.

Behaviour:
- Interface: one clock (clk_clk). Reset (reset_reset) is synchronous and active-high. No other clocks or async resets.
- Reset: state=IDLE, acc_start=0, mpu_eventi=0, gpi=14'h0000, all counters and flags cleared, sync flops cleared. Reset mid-job aborts silently with no eventi pulse.
- Event input path:
  - mpu_evento passes through a 2-flop synchronizer, then a rising-edge detect (ev_rise).
  - ev_rise asserts in the 3rd cycle after the first edge at which mpu_evento is sampled high.
  - A held-high mpu_evento produces exactly one ev_rise.
- gpi encoding: [1:0]=state code (IDLE 00, BUSY 01, DONE 10, START 11); [2]=error flag; [3]=timeout flag; [13:4]=row count. All gpi bits are registered.
- FSM:
  - IDLE: on ev_rise -> START.
  - START (exactly 1 cycle): acc_start=1; row count, timeout counter and both flags cleared -> BUSY.
  - BUSY:
    - Each acc_row_strobe increments row count, saturating at 1023.
    - Timeout counter increments every cycle.
    - acc_done -> DONE, with error flag = acc_error.
    - Otherwise, when the timeout counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES != 0) -> DONE with timeout flag = 1.
    - ev_rise in BUSY is ignored.
  - DONE: status held. On ev_rise -> START (new job; flags and count cleared in START).
- Latency: acc_start is high in the cycle after ev_rise. gpi[1:0] reads 11 for that cycle and 01 the next.
- mpu_eventi:
  - Asserted for exactly EVENTI_PULSE cycles starting the cycle after entry to DONE; fires once per job.
  - If ev_rise occurs during the pulse, the FSM goes to START and the pulse is still completed to full width.
- Simultaneous events:
  - acc_done and timeout in the same cycle: done wins, timeout flag = 0.
  - acc_row_strobe coincident with acc_done: the row is counted.
  - acc_done, acc_row_strobe and acc_error are ignored in IDLE, START and DONE.
- Timeout counter is 24 bits and cannot wrap, because it stops on leaving BUSY.

Test Plan:
1. Reset, then mpu_evento high for 1 cycle -> ev_rise at cycle 3; acc_start high exactly 1 cycle at cycle 4; gpi[1:0]=11 then 01.
2. 5 row strobes, then acc_done with acc_error=0 -> gpi=14'h0052 (rows 5, state DONE); mpu_eventi high for exactly 4 cycles, once.
3. TIMEOUT_CYCLES=100, no acc_done -> DONE after 100 BUSY cycles, gpi[3]=1, eventi pulse. Repeat with acc_done on the 100th cycle -> gpi[3]=0.
4. 1030 row strobes then acc_done with acc_error=1 -> gpi[13:4]=1023, gpi[2]=1.
5. ev_rise during BUSY -> no second acc_start. ev_rise in DONE -> new acc_start, gpi[13:2] cleared. mpu_evento held high 50 cycles -> single job start.
6. reset_reset asserted mid-BUSY -> next cycle gpi=0, acc_start=0, mpu_eventi=0, state IDLE; a later acc_done is ignored.
